// File: rtl/ebus_pkg.sv
// Shared EBUS types: function codes, handshake states, CONI/CONO bit positions.
// Data words use [0:35] numbering, bit 35 is the LSB.
package ebus_pkg;

  localparam int unsigned WORD_W = 36;
  localparam int unsigned CS_W   = 7;
  localparam int unsigned F_W    = 3;
  localparam int unsigned PI_W   = 8;
  localparam int unsigned PIA_W  = 3;

  typedef enum logic [F_W-1:0] {
    CONO   = 3'd0,
    CONI   = 3'd1,
    DATAO  = 3'd2,
    DATAI  = 3'd3,
    PI_VEC = 3'd4
  } tEBUSfunc;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ACK   = 2'd2,
    REL   = 2'd3
  } tEBUSstate;

  // CONO control bits
  localparam int unsigned CONO_FLUSH   = 29;
  localparam int unsigned CONO_CLR_OVR = 30;
  localparam int unsigned CONO_EN      = 32;
  localparam int unsigned PIA_LO       = 33;
  localparam int unsigned PIA_HI       = 35;

  // CONI status occupies bits [29:35]; first field lands on bit 29
  typedef struct packed {
    logic              overrun;
    logic              out_valid;
    logic              in_full;
    logic              enable;
    logic [PIA_W-1:0]  pia;
  } coni_t;

  localparam int unsigned CONI_PAD = WORD_W - $bits(coni_t);

  function automatic logic is_rd_func(input tEBUSfunc f);
    return (f == CONI) || (f == DATAI) || (f == PI_VEC);
  endfunction

endpackage

// File: rtl/ebus_dev_hs.sv
// EBUS demand/xfer handshake FSM with read setup counter; emits capture/commit strobes.
module ebus_dev_hs
  import ebus_pkg::*;
#(
  parameter int unsigned RD_SETUP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic demand,
  input  logic sel,
  input  logic rd,
  output logic xfer,
  output logic oe,
  output logic wr_cap_c,
  output logic rd_start_c,
  output logic rd_commit_c,
  output logic end_c
);

  localparam int unsigned CNT_W = (RD_SETUP > 1) ? $clog2(RD_SETUP) : 1;

  tEBUSstate state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic xfer_d, oe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      xfer  <= 1'b0;
      oe    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      xfer  <= xfer_d;
      oe    <= oe_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    xfer_d      = xfer;
    oe_d        = oe;
    wr_cap_c    = 1'b0;
    rd_start_c  = 1'b0;
    rd_commit_c = 1'b0;
    end_c       = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          if (rd) begin
            state_d    = SETUP;
            oe_d       = 1'b1;
            cnt_d      = CNT_W'(RD_SETUP - 1);
            rd_start_c = 1'b1;
          end else begin
            state_d  = ACK;
            xfer_d   = 1'b1;
            wr_cap_c = 1'b1;
          end
        end
      end
      SETUP: begin
        // master gave up before xfer: release without side effect
        if (!demand) begin
          state_d = REL;
          oe_d    = 1'b0;
          end_c   = 1'b1;
        end else if (cnt == '0) begin
          state_d = ACK;
          xfer_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        if (!demand) begin
          state_d     = REL;
          xfer_d      = 1'b0;
          oe_d        = 1'b0;
          rd_commit_c = oe;
          end_c       = 1'b1;
        end
      end
      REL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/ebus_dev.sv
// Generic EBUS device responder: CONO/CONI/DATAO/DATAI/PI-vector cycles,
// one-word DATAO/DATAI buffers toward local logic, and PI request posting.
module ebus_dev
  import ebus_pkg::*;
#(
  parameter logic [0:CS_W-1]   DEV_CODE = 7'o020,
  parameter int unsigned       RD_SETUP = 2,
  parameter logic [0:WORD_W-1] VECTOR   = 36'o0
) (
  input  logic              clk,
  input  logic              CROBAR,
  input  logic              ebusReset,
  input  logic [0:CS_W-1]   ebusCS,
  input  logic [F_W-1:0]    ebusF,
  input  logic              ebusDemand,
  input  logic [0:WORD_W-1] ebusDataIn,
  output logic [0:WORD_W-1] ebusDataOut,
  output logic              ebusDataOE,
  output logic              ebusXfer,
  output logic [0:PI_W-1]   ebusPI,
  output logic [0:WORD_W-1] outData,
  output logic              outValid,
  input  logic              outReady,
  input  logic [0:WORD_W-1] inData,
  input  logic              inValid,
  output logic              inReady
);

  logic rst;
  assign rst = CROBAR | ebusReset;

  logic [PIA_W-1:0]  pia, pia_d;
  logic              enable, enable_d;
  logic              overrun, overrun_d;
  logic              out_valid_d;
  logic [0:WORD_W-1] out_data_d;
  logic              in_full, in_full_d;
  logic [0:WORD_W-1] in_data, in_data_d;
  logic              datai_busy, datai_busy_d;
  logic              in_ready_d;
  logic [0:PI_W-1]   pi_d;
  logic [0:WORD_W-1] data_out_d;
  tEBUSfunc          func_q, func_d;

  tEBUSfunc          fn;
  logic              int_req, sel, rd;
  coni_t             status;
  logic [0:WORD_W-1] rd_word;
  logic              wr_cap_c, rd_start_c, rd_commit_c, end_c;

  assign fn      = tEBUSfunc'(ebusF);
  assign int_req = enable & (in_full | ~outValid | overrun);
  assign rd      = is_rd_func(fn);

  // Controller select; PI-vector answers by level instead of device code
  always_comb begin
    sel = 1'b0;
    case (fn)
      CONO, CONI, DATAO, DATAI: sel = ebusDemand & (ebusCS == DEV_CODE);
      PI_VEC: sel = ebusDemand & (ebusCS[4:6] == pia) & (pia != '0) & int_req;
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    status  = '{overrun: overrun, out_valid: outValid, in_full: in_full,
                enable: enable, pia: pia};
    rd_word = '0;
    case (fn)
      CONI:    rd_word = {{CONI_PAD{1'b0}}, status};
      DATAI:   rd_word = in_full ? in_data : '0;
      PI_VEC:  rd_word = VECTOR;
      default: rd_word = '0;
    endcase
  end

  ebus_dev_hs #(.RD_SETUP(RD_SETUP)) u_hs (
    .clk         (clk),
    .rst         (rst),
    .demand      (ebusDemand),
    .sel         (sel),
    .rd          (rd),
    .xfer        (ebusXfer),
    .oe          (ebusDataOE),
    .wr_cap_c    (wr_cap_c),
    .rd_start_c  (rd_start_c),
    .rd_commit_c (rd_commit_c),
    .end_c       (end_c)
  );

  always_comb begin
    pia_d        = pia;
    enable_d     = enable;
    overrun_d    = overrun;
    out_valid_d  = outValid;
    out_data_d   = outData;
    in_full_d    = in_full;
    in_data_d    = in_data;
    datai_busy_d = datai_busy;
    func_d       = func_q;
    data_out_d   = ebusDataOut;

    if (outValid && outReady) out_valid_d = 1'b0;
    if (inValid && inReady) begin
      in_full_d = 1'b1;
      in_data_d = inData;
    end

    if (wr_cap_c || rd_start_c) func_d = fn;

    // read data is snapshotted at selection and held for the whole cycle
    if (rd_start_c) data_out_d = rd_word;
    else if (end_c) data_out_d = '0;

    if (rd_start_c && fn == DATAI) datai_busy_d = 1'b1;
    else if (end_c) datai_busy_d = 1'b0;

    if (wr_cap_c) begin
      case (fn)
        CONO: begin
          pia_d    = ebusDataIn[PIA_LO:PIA_HI];
          enable_d = ebusDataIn[CONO_EN];
          if (ebusDataIn[CONO_CLR_OVR]) overrun_d = 1'b0;
          // flush wins over a same-cycle local push or pop
          if (ebusDataIn[CONO_FLUSH]) begin
            out_valid_d = 1'b0;
            in_full_d   = 1'b0;
          end
        end
        DATAO: begin
          if (!outValid) begin
            out_data_d  = ebusDataIn;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (rd_commit_c && func_q == DATAI) in_full_d = 1'b0;

    pi_d = '0;
    if (int_req && pia != '0) pi_d[pia] = 1'b1;

    in_ready_d = ~in_full_d & ~datai_busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pia         <= '0;
      enable      <= 1'b0;
      overrun     <= 1'b0;
      outValid    <= 1'b0;
      outData     <= '0;
      in_full     <= 1'b0;
      in_data     <= '0;
      datai_busy  <= 1'b0;
      inReady     <= 1'b1;
      ebusPI      <= '0;
      ebusDataOut <= '0;
      func_q      <= CONO;
    end else begin
      pia         <= pia_d;
      enable      <= enable_d;
      overrun     <= overrun_d;
      outValid    <= out_valid_d;
      outData     <= out_data_d;
      in_full     <= in_full_d;
      in_data     <= in_data_d;
      datai_busy  <= datai_busy_d;
      inReady     <= in_ready_d;
      ebusPI      <= pi_d;
      ebusDataOut <= data_out_d;
      func_q      <= func_d;
    end
  end

endmodule
